l1_l2_arbiter: RTL and testbench
================================

Name: l1_l2_arbiter

Overview:
Arbitrates line-sized misses/writebacks from the split L1 caches (I-cache, D-cache; 128-bit lines) onto the single port of the unified L2 (256-bit lines). One outstanding L2 transaction at a time. Maps each 128-bit L1 line onto one half of an L2 line using address bit 4 (the L2 line offset bit). Returns the addressed half to the granted client.

Parameters:
ROUND_ROBIN, 1, 1 = alternate grant on simultaneous requests; 0 = D-cache always wins ties.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
icache_addr  in  16  I-cache line address, lc3b_c_addr
icache_read  in  1  I-cache line read request, held until icache_resp
icache_resp  out  1  one-cycle completion pulse to I-cache
icache_rdata  out  128  returned line, lc3b_c_line
dcache_addr  in  16  D-cache line address
dcache_read  in  1  D-cache line read request, held until dcache_resp
dcache_write  in  1  D-cache line writeback request, held until dcache_resp
dcache_wdata  in  128  writeback line
dcache_resp  out  1  one-cycle completion pulse to D-cache
dcache_rdata  out  128  returned line
l2_addr  out  16  L2 address, lc3b_c2_addr
l2_read  out  1  L2 read strobe, held until l2_resp
l2_write  out  1  L2 write strobe, held until l2_resp
l2_wdata  out  256  L2 write line, lc3b_c2_line
l2_wmask  out  2  half-line write enable; bit0 = bits[127:0], bit1 = bits[255:128]
l2_rdata  in  256  L2 read line
l2_resp  in  1  L2 completion, single-cycle pulse

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, DONE. All outputs registered.
- Reset (async, rst_n=0): state=IDLE; l2_read=l2_write=0; l2_addr=0; l2_wdata=0; l2_wmask=0; both resp=0; both rdata=0; last_grant=I. Applies mid-transaction too: the L2 request drops immediately and the pending transaction is abandoned with no client resp.
- IDLE: requests sampled only here. dreq = dcache_read|dcache_write; ireq = icache_read.
  - Only one request: grant it.
  - Both with ROUND_ROBIN=1: grant the client not equal to last_grant.
  - Both with ROUND_ROBIN=0: grant D.
  - On grant: latch the client address into l2_addr with bits [3:0] forced to 0. Set last_grant. Next state is BUSY_I or BUSY_D. l2_read/l2_write rise in the first BUSY cycle (1-cycle grant latency).
- D-cache write (dcache_write=1): l2_write=1, l2_wdata={wdata,wdata}, l2_wmask = addr[4] ? 2'b10 : 2'b01. If dcache_read and dcache_write are both high, treat the request as a write. Reads: l2_read=1, l2_wmask=0.
- BUSY_x: hold l2_addr, l2_read/l2_write, l2_wdata and l2_wmask stable until l2_resp=1. Wait indefinitely.
- On l2_resp in BUSY_x:
  - Deassert l2_read/l2_write and l2_wmask.
  - Capture the selected half: latched addr[4] ? l2_rdata[255:128] : l2_rdata[127:0].
  - Load it into x_rdata (reads only; writes leave rdata unchanged).
  - Set x_resp=1 and go to DONE.
- DONE: x_resp=1 for exactly this one cycle, then IDLE. Clients drop their request on the edge ending DONE, so they are not regranted.
- rdata holds its value until the next read response to that client.
- l2_resp seen outside BUSY: ignored.
- Latency: request asserted in IDLE cycle N → L2 strobe in cycle N+1. l2_resp in cycle M → client resp in cycle M+1 → IDLE in cycle M+2.
- Min L1-miss turnaround = L2 latency + 3 cycles.

Test Plan:
1. Single I-cache read: icache_addr=0x1234, L2 returns l2_rdata upper=0xAA..AA, lower=0x55..55 after 4 cycles → l2_addr=0x1230 with l2_read=1 one cycle after request; icache_rdata=0xAA..AA (addr[4]=1); icache_resp high exactly 1 cycle.
2. D-cache writeback to addr=0x0048 with wdata=0x0123..EF → l2_write=1, l2_addr=0x0040, l2_wmask=2'b01, l2_wdata={wdata,wdata}; dcache_resp pulses 1 cycle and dcache_rdata is unchanged.
3. Simultaneous I-read and D-read from reset, ROUND_ROBIN=1 → D granted first. Next tie → I. Next tie → D. No request is lost, and each client gets exactly one resp per request.
4. Same as 3 with ROUND_ROBIN=0 and D requesting continuously → D granted every transaction; I is served only when D is idle.
5. L2 latency of 50 cycles → the L2 strobe, l2_addr and l2_wdata stay stable for all 50 cycles, and no client resp occurs before l2_resp.
6. rst_n pulled low in the middle of BUSY_D, then released → all outputs are 0 immediately (asynchronously), the FSM is in IDLE, and a fresh icache request afterwards completes normally with correct data.

Source files
------------

// File: rtl/l1_l2_arbiter_if.sv
// ---------------------------------------------------------------------------
// l1_l2_arbiter_if
//   Bundles the split-L1 request/response signals and the unified-L2 port
//   that meet at the L1/L2 arbiter.
//
//   master : the surrounding memory system (I-cache, D-cache and L2), which
//            drives client requests and the L2 response.
//   slave  : the arbiter, which drives client responses and the L2 request.
//
//   I-cache : icache_addr[15:0], icache_read, icache_resp, icache_rdata[127:0]
//   D-cache : dcache_addr[15:0], dcache_read, dcache_write,
//             dcache_wdata[127:0], dcache_resp, dcache_rdata[127:0]
//   L2      : l2_addr[15:0], l2_read, l2_write, l2_wdata[255:0],
//             l2_wmask[1:0], l2_rdata[255:0], l2_resp
// ---------------------------------------------------------------------------
interface l1_l2_arbiter_if;
    logic [15:0]  icache_addr;
    logic         icache_read;
    logic         icache_resp;
    logic [127:0] icache_rdata;

    logic [15:0]  dcache_addr;
    logic         dcache_read;
    logic         dcache_write;
    logic [127:0] dcache_wdata;
    logic         dcache_resp;
    logic [127:0] dcache_rdata;

    logic [15:0]  l2_addr;
    logic         l2_read;
    logic         l2_write;
    logic [255:0] l2_wdata;
    logic [1:0]   l2_wmask;
    logic [255:0] l2_rdata;
    logic         l2_resp;

    modport master (
        output icache_addr, icache_read,
        input  icache_resp, icache_rdata,
        output dcache_addr, dcache_read, dcache_write, dcache_wdata,
        input  dcache_resp, dcache_rdata,
        input  l2_addr, l2_read, l2_write, l2_wdata, l2_wmask,
        output l2_rdata, l2_resp
    );

    modport slave (
        input  icache_addr, icache_read,
        output icache_resp, icache_rdata,
        input  dcache_addr, dcache_read, dcache_write, dcache_wdata,
        output dcache_resp, dcache_rdata,
        output l2_addr, l2_read, l2_write, l2_wdata, l2_wmask,
        input  l2_rdata, l2_resp
    );
endinterface

// File: rtl/l1_l2_arbiter.sv
// ---------------------------------------------------------------------------
// l1_l2_arbiter
//   Arbitrates 128-bit line misses/writebacks from the I-cache and D-cache
//   onto the single 256-bit-line port of the unified L2. One L2 transaction
//   is outstanding at a time. Each L1 line maps onto one half of an L2 line
//   selected by address bit 4; that half is returned to the granted client.
//
//   Parameters:
//     ROUND_ROBIN : 1 = alternate grants on simultaneous requests,
//                   0 = D-cache always wins ties.
//   Ports:
//     clk   : clock, all state updates on the rising edge
//     rst_n : asynchronous active-low reset
//     bus   : slave side of l1_l2_arbiter_if (client + L2 signals)
//
//   All outputs are registered. Flow: IDLE -> BUSY_I/BUSY_D -> DONE -> IDLE.
//   Requests are only sampled in IDLE; the L2 strobe rises one cycle after
//   the request is seen and the client response pulses for the single DONE
//   cycle following l2_resp.
// ---------------------------------------------------------------------------
module l1_l2_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    l1_l2_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE
    } state_t;

    typedef enum logic {
        CLIENT_I,
        CLIENT_D
    } client_t;

    state_t       state_q, state_d;
    client_t      last_grant_q, last_grant_d;

    logic [15:0]  l2_addr_q, l2_addr_d;
    logic         l2_read_q, l2_read_d;
    logic         l2_write_q, l2_write_d;
    logic [255:0] l2_wdata_q, l2_wdata_d;
    logic [1:0]   l2_wmask_q, l2_wmask_d;
    logic         icache_resp_q, icache_resp_d;
    logic [127:0] icache_rdata_q, icache_rdata_d;
    logic         dcache_resp_q, dcache_resp_d;
    logic [127:0] dcache_rdata_q, dcache_rdata_d;

    logic         ireq;
    logic         dreq;
    logic         pick_d;
    logic [127:0] l2_half;

    // Arbitration decision, only meaningful while IDLE. D wins when it is the
    // sole requester, when ties always go to D, or when I had the last grant.
    always_comb begin
        ireq   = bus.icache_read;
        dreq   = bus.dcache_read | bus.dcache_write;
        pick_d = dreq & (~ireq | ~ROUND_ROBIN | (last_grant_q == CLIENT_I));
    end

    // Line half addressed by the latched request (bit 4 = L2 line offset).
    always_comb begin
        l2_half = l2_addr_q[4] ? bus.l2_rdata[255:128] : bus.l2_rdata[127:0];
    end

    // State and registered-output storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= CLIENT_I;
            l2_addr_q      <= '0;
            l2_read_q      <= 1'b0;
            l2_write_q     <= 1'b0;
            l2_wdata_q     <= '0;
            l2_wmask_q     <= '0;
            icache_resp_q  <= 1'b0;
            icache_rdata_q <= '0;
            dcache_resp_q  <= 1'b0;
            dcache_rdata_q <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            l2_addr_q      <= l2_addr_d;
            l2_read_q      <= l2_read_d;
            l2_write_q     <= l2_write_d;
            l2_wdata_q     <= l2_wdata_d;
            l2_wmask_q     <= l2_wmask_d;
            icache_resp_q  <= icache_resp_d;
            icache_rdata_q <= icache_rdata_d;
            dcache_resp_q  <= dcache_resp_d;
            dcache_rdata_q <= dcache_rdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d      = BUSY_D;
                    last_grant_d = CLIENT_D;
                end else if (ireq) begin
                    state_d      = BUSY_I;
                    last_grant_d = CLIENT_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.l2_resp) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: computes the next value of every registered output.
    // The L2 request is loaded in IDLE so it appears in the first BUSY cycle,
    // and cleared on l2_resp so it is already low during DONE.
    always_comb begin
        l2_addr_d      = l2_addr_q;
        l2_read_d      = l2_read_q;
        l2_write_d     = l2_write_q;
        l2_wdata_d     = l2_wdata_q;
        l2_wmask_d     = l2_wmask_q;
        icache_rdata_d = icache_rdata_q;
        dcache_rdata_d = dcache_rdata_q;
        icache_resp_d  = 1'b0;
        dcache_resp_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    l2_addr_d = {bus.dcache_addr[15:4], 4'h0};
                    // A simultaneous read+write is serviced as a writeback.
                    if (bus.dcache_write) begin
                        l2_read_d  = 1'b0;
                        l2_write_d = 1'b1;
                        l2_wdata_d = {bus.dcache_wdata, bus.dcache_wdata};
                        l2_wmask_d = bus.dcache_addr[4] ? 2'b10 : 2'b01;
                    end else begin
                        l2_read_d  = 1'b1;
                        l2_write_d = 1'b0;
                        l2_wmask_d = '0;
                    end
                end else if (ireq) begin
                    l2_addr_d  = {bus.icache_addr[15:4], 4'h0};
                    l2_read_d  = 1'b1;
                    l2_write_d = 1'b0;
                    l2_wmask_d = '0;
                end
            end
            BUSY_I: begin
                if (bus.l2_resp) begin
                    l2_read_d      = 1'b0;
                    l2_write_d     = 1'b0;
                    l2_wmask_d     = '0;
                    icache_rdata_d = l2_half;
                    icache_resp_d  = 1'b1;
                end
            end
            BUSY_D: begin
                if (bus.l2_resp) begin
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                    l2_wmask_d = '0;
                    if (!l2_write_q) begin
                        dcache_rdata_d = l2_half;
                    end
                    dcache_resp_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.l2_addr      = l2_addr_q;
    assign bus.l2_read      = l2_read_q;
    assign bus.l2_write     = l2_write_q;
    assign bus.l2_wdata     = l2_wdata_q;
    assign bus.l2_wmask     = l2_wmask_q;
    assign bus.icache_resp  = icache_resp_q;
    assign bus.icache_rdata = icache_rdata_q;
    assign bus.dcache_resp  = dcache_resp_q;
    assign bus.dcache_rdata = dcache_rdata_q;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l1_l2_arbiter
//   Two arbiter instances (round-robin and fixed-priority) share one set of
//   stimulus variables; 'sel' routes the request/response strobes to one of
//   them and picks which instance's outputs are observed. Expected values
//   come from a transaction-level model: who should win, what the L2 request
//   must look like, and what each client's line should read back.
// ---------------------------------------------------------------------------
module tb_l1_l2_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic sel;          // 0: ROUND_ROBIN=1 instance, 1: ROUND_ROBIN=0 instance

    logic [15:0]  icache_addr;
    logic         icache_read;
    logic [15:0]  dcache_addr;
    logic         dcache_read;
    logic         dcache_write;
    logic [127:0] dcache_wdata;
    logic [255:0] l2_rdata;
    logic         l2_resp;

    l1_l2_arbiter_if bus_rr ();
    l1_l2_arbiter_if bus_fp ();

    l1_l2_arbiter #(.ROUND_ROBIN(1'b1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
    l1_l2_arbiter #(.ROUND_ROBIN(1'b0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp));

    assign bus_rr.icache_addr  = icache_addr;
    assign bus_rr.icache_read  = icache_read & ~sel;
    assign bus_rr.dcache_addr  = dcache_addr;
    assign bus_rr.dcache_read  = dcache_read & ~sel;
    assign bus_rr.dcache_write = dcache_write & ~sel;
    assign bus_rr.dcache_wdata = dcache_wdata;
    assign bus_rr.l2_rdata     = l2_rdata;
    assign bus_rr.l2_resp      = l2_resp & ~sel;

    assign bus_fp.icache_addr  = icache_addr;
    assign bus_fp.icache_read  = icache_read & sel;
    assign bus_fp.dcache_addr  = dcache_addr;
    assign bus_fp.dcache_read  = dcache_read & sel;
    assign bus_fp.dcache_write = dcache_write & sel;
    assign bus_fp.dcache_wdata = dcache_wdata;
    assign bus_fp.l2_rdata     = l2_rdata;
    assign bus_fp.l2_resp      = l2_resp & sel;

    logic [15:0]  o_l2_addr;
    logic         o_l2_read, o_l2_write;
    logic [255:0] o_l2_wdata;
    logic [1:0]   o_l2_wmask;
    logic         o_iresp, o_dresp;
    logic [127:0] o_irdata, o_drdata;

    assign o_l2_addr  = sel ? bus_fp.l2_addr      : bus_rr.l2_addr;
    assign o_l2_read  = sel ? bus_fp.l2_read      : bus_rr.l2_read;
    assign o_l2_write = sel ? bus_fp.l2_write     : bus_rr.l2_write;
    assign o_l2_wdata = sel ? bus_fp.l2_wdata     : bus_rr.l2_wdata;
    assign o_l2_wmask = sel ? bus_fp.l2_wmask     : bus_rr.l2_wmask;
    assign o_iresp    = sel ? bus_fp.icache_resp  : bus_rr.icache_resp;
    assign o_dresp    = sel ? bus_fp.dcache_resp  : bus_rr.dcache_resp;
    assign o_irdata   = sel ? bus_fp.icache_rdata : bus_rr.icache_rdata;
    assign o_drdata   = sel ? bus_fp.dcache_rdata : bus_rr.dcache_rdata;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic         model_last_d;     // 1 when the most recent grant went to D
    logic [127:0] exp_irdata;
    logic [127:0] exp_drdata;
    logic         i_pend, d_pend;   // client is holding a request

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (sel=%0d t=%0t): got %0h expected %0h", tag, sel, $time, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [255:0] rand256();
        return {rand128(), rand128()};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_l2_addr"},  o_l2_addr, 0);
        check({tag, "_strobes"},  {o_l2_read, o_l2_write}, 0);
        check({tag, "_l2_wdata"}, o_l2_wdata, 0);
        check({tag, "_l2_wmask"}, o_l2_wmask, 0);
        check({tag, "_resps"},    {o_iresp, o_dresp}, 0);
        check({tag, "_irdata"},   o_irdata, 0);
        check({tag, "_drdata"},   o_drdata, 0);
    endtask

    task automatic model_reset();
        model_last_d = 1'b0;
        exp_irdata   = '0;
        exp_drdata   = '0;
    endtask

    task automatic clear_requests();
        icache_read  = 1'b0;
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        l2_resp      = 1'b0;
        i_pend       = 1'b0;
        d_pend       = 1'b0;
    endtask

    // Leaves the bench just after a rising edge with the DUT in IDLE.
    task automatic do_reset();
        rst_n = 1'b0;
        clear_requests();
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Entered just after the rising edge that starts an IDLE cycle, with
    // the pending requests already driven. L2 answers after 'lat' strobe
    // cycles with line 'rd'. Returns just after the edge ending DONE, with
    // the winning client's request dropped.
    task automatic do_txn(input int lat, input logic [255:0] rd);
        logic         win_d;
        logic         wr;
        logic [15:0]  a;
        logic [1:0]   exp_mask;
        logic [255:0] exp_wd;
        logic [127:0] half;

        @(negedge clk);
        check("idle_strobes", {o_l2_read, o_l2_write}, 0);
        check("resp_once", {o_iresp, o_dresp}, 0);

        win_d    = d_pend && (!i_pend || sel || !model_last_d);
        model_last_d = win_d;
        a        = win_d ? dcache_addr : icache_addr;
        wr       = win_d && dcache_write;
        exp_mask = wr ? (a[4] ? 2'b10 : 2'b01) : 2'b00;
        exp_wd   = {dcache_wdata, dcache_wdata};

        for (int k = 0; k < lat; k++) begin
            @(posedge clk);
            #1;
            l2_rdata = (k == lat - 1) ? rd : rand256();
            l2_resp  = (k == lat - 1);
            @(negedge clk);
            check("l2_read", o_l2_read, !wr);
            check("l2_write", o_l2_write, wr);
            check("l2_addr", o_l2_addr, {a[15:4], 4'h0});
            check("l2_wmask", o_l2_wmask, exp_mask);
            if (wr) check("l2_wdata", o_l2_wdata, exp_wd);
            check("early_resp", {o_iresp, o_dresp}, 0);
        end

        @(posedge clk);
        #1;
        l2_resp  = 1'b0;
        l2_rdata = rand256();
        @(negedge clk);
        half = a[4] ? rd[255:128] : rd[127:0];
        if (!wr) begin
            if (win_d) exp_drdata = half;
            else       exp_irdata = half;
        end
        check("strobe_drop", {o_l2_read, o_l2_write}, 0);
        check("wmask_drop", o_l2_wmask, 0);
        check("icache_resp", o_iresp, !win_d);
        check("dcache_resp", o_dresp, win_d);
        check("icache_rdata", o_irdata, exp_irdata);
        check("dcache_rdata", o_drdata, exp_drdata);

        @(posedge clk);
        #1;
        if (win_d) begin
            dcache_read  = 1'b0;
            dcache_write = 1'b0;
            d_pend       = 1'b0;
        end else begin
            icache_read = 1'b0;
            i_pend      = 1'b0;
        end
    endtask

    // One IDLE period with a stray l2_resp that must be ignored.
    task automatic idle_cycle();
        l2_resp  = 1'b1;
        l2_rdata = rand256();
        @(negedge clk);
        check("idle_strobes", {o_l2_read, o_l2_write}, 0);
        @(posedge clk);
        #1;
        l2_resp = 1'b0;
        @(negedge clk);
        check("stray_resp", {o_iresp, o_dresp}, 0);
        check("stray_irdata", o_irdata, exp_irdata);
        check("stray_drdata", o_drdata, exp_drdata);
        @(posedge clk);
        #1;
    endtask

    task automatic req_i(input logic [15:0] addr);
        icache_addr = addr;
        icache_read = 1'b1;
        i_pend      = 1'b1;
    endtask

    task automatic req_d(input logic [15:0] addr, input int mode, input logic [127:0] wd);
        dcache_addr  = addr;
        dcache_read  = (mode != 1);
        dcache_write = (mode != 0);
        dcache_wdata = wd;
        d_pend       = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel          = 1'b0;
        icache_addr  = '0;
        dcache_addr  = '0;
        dcache_wdata = '0;
        l2_rdata     = '0;
        clear_requests();

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_reset();

            // Ties from reset: three back-to-back, winner re-requests each time.
            req_i(16'h0100);
            req_d(16'h0210, 0, '0);
            for (int t = 0; t < 3; t++) begin
                do_txn(2, rand256());
                if (!i_pend) req_i(16'($urandom()));
                if (!d_pend) req_d(16'($urandom()), 0, '0);
            end
            while (i_pend || d_pend) do_txn(1, rand256());

            // Single I-cache read, upper half returned.
            req_i(16'h1234);
            do_txn(4, {{16{8'hAA}}, {16{8'h55}}});

            // D-cache writeback to the lower half; dcache_rdata must not move.
            req_d(16'h0048, 1, 128'h0123456789ABCDEF0123456789ABCDEF);
            do_txn(3, rand256());

            // Long L2 latency on a read+write (serviced as a write).
            req_d(16'h7FF0, 2, rand128());
            do_txn(50, rand256());

            for (int it = 0; it < 60; it++) begin
                if (!i_pend && ($urandom_range(1, 0) == 1)) req_i(16'($urandom()));
                if (!d_pend && ($urandom_range(1, 0) == 1))
                    req_d(16'($urandom()), int'($urandom_range(2, 0)), rand128());
                if (i_pend || d_pend) do_txn(int'($urandom_range(6, 1)), rand256());
                else                  idle_cycle();
            end
            while (i_pend || d_pend) do_txn(1, rand256());

            // Reset in the middle of a D-cache writeback.
            req_d(16'h0ABC, 1, rand128());
            @(negedge clk);
            @(negedge clk);
            check("mid_busy_write", o_l2_write, 1);
            #2;
            rst_n = 1'b0;
            #1;
            check_all_zero("async_reset");
            clear_requests();
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            model_reset();
            @(negedge clk);
            check("abandoned_resp", {o_iresp, o_dresp}, 0);
            check("abandoned_strobes", {o_l2_read, o_l2_write}, 0);
            @(posedge clk);
            #1;
            req_i(16'h5A5F);
            do_txn(3, rand256());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
